pyrxlnctrl_pack: RTL and testbench

Receive-side payload packer between the link-controller payload decoder and the ACL/SCO receive buffers. It takes the serial decoded payload bit stream and packs it LSB-first into 32-bit words. It drives the `rxlnctrl_*` write port of the receive buffers and classifies each packet as ACL or SCO. At payload end it reports commit, discard or duplicate for the ACL buffer. It is the receive counterpart of the transmit bit-select path, which reads bit `pybitcount[4:0]` of word `pybitcount[12:5]`.

---
 rtl/pyrxlnctrl_pack.sv | 142 ++++++++++++++
 tb/tb_pyrxlnctrl_pack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pyrxlnctrl_pack.sv
// Receive payload packer: serial decoded payload bits -> 32-bit LSB-first words for the ACL/SCO rx buffers.
// Build option RXPY_SEQN_FILTER_EN enables the ACL SEQN duplicate filter (default: disabled).
module pyrxlnctrl_pack (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        ms_tslot_p,
  input  logic        dec_LMPcmd,
  input  logic        rx_reservedslot,
  input  logic        dec_py_period,
  input  logic        dec_pybit,
  input  logic        dec_pybit_valid,
  input  logic        dec_py_endp,
  input  logic        dec_crc_ok,
  input  logic        dec_seqn,
  output logic [7:0]  rxlnctrl_addr,
  output logic [31:0] rxlnctrl_din,
  output logic        rxlnctrl_we,
  output logic        rxlnctrlacl_cs,
  output logic        rxlnctrlsco_cs,
  output logic [12:0] rx_pybitcount,
  output logic        rxacl_commit_p,
  output logic        rxacl_discard_p,
  output logic        rxacl_dup_p,
  output logic        rx_overflow
);

`ifdef RXPY_SEQN_FILTER_EN
  localparam logic SEQN_FILTER = 1'b1;
`else
  localparam logic SEQN_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t      state;
  logic        py_period_p1;
  logic        lmp_slot;
  logic [13:0] count;
  logic [31:0] word;
  logic        crc_l;
  logic        seqn_l;
  logic        acl_l;
  logic        last_seqn;

  logic        take_bit;
  logic [13:0] count_inc;
  logic [31:0] word_ins;

  assign rxlnctrlacl_cs = dec_py_period & (lmp_slot | ~rx_reservedslot);
  assign rxlnctrlsco_cs = dec_py_period & ~lmp_slot & rx_reservedslot;

  // Count stops at 8192; the 13-bit view holds at its maximum once saturated.
  assign rx_pybitcount = count[13] ? 13'h1FFF : count[12:0];

  assign take_bit  = dec_pybit_valid & ~count[13];
  assign count_inc = count + 14'(take_bit);
  assign word_ins  = word | (32'(dec_pybit) << count[4:0]);

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state           <= IDLE;
      py_period_p1    <= 1'b0;
      lmp_slot        <= 1'b0;
      count           <= '0;
      word            <= '0;
      crc_l           <= 1'b0;
      seqn_l          <= 1'b0;
      acl_l           <= 1'b0;
      last_seqn       <= 1'b1;
      rxlnctrl_addr   <= '0;
      rxlnctrl_din    <= '0;
      rxlnctrl_we     <= 1'b0;
      rxacl_commit_p  <= 1'b0;
      rxacl_discard_p <= 1'b0;
      rxacl_dup_p     <= 1'b0;
      rx_overflow     <= 1'b0;
    end else begin
      py_period_p1    <= dec_py_period;
      rxlnctrl_we     <= 1'b0;
      rxacl_commit_p  <= 1'b0;
      rxacl_discard_p <= 1'b0;
      rxacl_dup_p     <= 1'b0;
      if (ms_tslot_p) lmp_slot <= dec_LMPcmd;

      case (state)
        IDLE: begin
          if (dec_py_period && !py_period_p1) begin
            state       <= COLLECT;
            count       <= '0;
            word        <= '0;
            rx_overflow <= 1'b0;
          end
        end
        COLLECT: begin
          if (take_bit) begin
            count <= count_inc;
            if (count[4:0] == 5'd31) begin
              rxlnctrl_we   <= 1'b1;
              rxlnctrl_din  <= word_ins;
              rxlnctrl_addr <= count[12:5];
              word          <= '0;
            end else begin
              word <= word_ins;
            end
          end else if (dec_pybit_valid) begin
            rx_overflow <= 1'b1;
          end
          // The endp-cycle bit is already in count_inc, so a just-completed word goes straight to DONE.
          if (dec_py_endp) begin
            crc_l  <= dec_crc_ok;
            seqn_l <= dec_seqn;
            acl_l  <= lmp_slot | ~rx_reservedslot;
            state  <= (count_inc[4:0] != 5'd0) ? FLUSH : DONE;
          end else if (!dec_py_period) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          rxlnctrl_we   <= 1'b1;
          rxlnctrl_din  <= word;
          rxlnctrl_addr <= count[12:5];
          state         <= DONE;
        end
        DONE: begin
          if (acl_l) begin
            if (!crc_l || rx_overflow) begin
              rxacl_discard_p <= 1'b1;
            end else if (SEQN_FILTER && (seqn_l == last_seqn)) begin
              rxacl_dup_p <= 1'b1;
            end else begin
              rxacl_commit_p <= 1'b1;
              last_seqn      <= seqn_l;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyrxlnctrl_pack.sv
// Directed bench for pyrxlnctrl_pack: packing, flush, status timing, routing, overflow and reset.
module tb_pyrxlnctrl_pack;
  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        ms_tslot_p = 1'b0;
  logic        dec_LMPcmd = 1'b0;
  logic        rx_reservedslot = 1'b0;
  logic        dec_py_period = 1'b0;
  logic        dec_pybit = 1'b0;
  logic        dec_pybit_valid = 1'b0;
  logic        dec_py_endp = 1'b0;
  logic        dec_crc_ok = 1'b0;
  logic        dec_seqn = 1'b0;
  logic [7:0]  rxlnctrl_addr;
  logic [31:0] rxlnctrl_din;
  logic        rxlnctrl_we;
  logic        rxlnctrlacl_cs;
  logic        rxlnctrlsco_cs;
  logic [12:0] rx_pybitcount;
  logic        rxacl_commit_p;
  logic        rxacl_discard_p;
  logic        rxacl_dup_p;
  logic        rx_overflow;

  pyrxlnctrl_pack dut (
    .clk_6M(clk_6M), .rst(rst), .ms_tslot_p(ms_tslot_p), .dec_LMPcmd(dec_LMPcmd),
    .rx_reservedslot(rx_reservedslot), .dec_py_period(dec_py_period), .dec_pybit(dec_pybit),
    .dec_pybit_valid(dec_pybit_valid), .dec_py_endp(dec_py_endp), .dec_crc_ok(dec_crc_ok),
    .dec_seqn(dec_seqn), .rxlnctrl_addr(rxlnctrl_addr), .rxlnctrl_din(rxlnctrl_din),
    .rxlnctrl_we(rxlnctrl_we), .rxlnctrlacl_cs(rxlnctrlacl_cs), .rxlnctrlsco_cs(rxlnctrlsco_cs),
    .rx_pybitcount(rx_pybitcount), .rxacl_commit_p(rxacl_commit_p),
    .rxacl_discard_p(rxacl_discard_p), .rxacl_dup_p(rxacl_dup_p), .rx_overflow(rx_overflow)
  );

  always #5 clk_6M = ~clk_6M;

  int cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int endp_cyc, b32_cyc;
  int commit_cnt, discard_cnt, dup_cnt, commit_cyc;
  int saw_acl, saw_sco, both_cnt = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(negedge clk_6M) begin
    if (rxlnctrl_we) begin
      wr_addr.push_back(rxlnctrl_addr);
      wr_data.push_back(rxlnctrl_din);
      wr_cyc.push_back(cyc);
    end
    if (rxacl_commit_p) begin commit_cnt++; commit_cyc = cyc; end
    if (rxacl_discard_p) discard_cnt++;
    if (rxacl_dup_p) dup_cnt++;
    if (rxlnctrlacl_cs) saw_acl = 1;
    if (rxlnctrlsco_cs) saw_sco = 1;
    if (rxlnctrlacl_cs && rxlnctrlsco_cs) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wa(input int i);
    return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk_6M); #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    commit_cnt = 0; discard_cnt = 0; dup_cnt = 0; commit_cyc = -1;
    saw_acl = 0; saw_sco = 0;
  endtask

  task automatic slot(input logic lmp);
    tick(); ms_tslot_p = 1'b1; dec_LMPcmd = lmp;
    tick(); ms_tslot_p = 1'b0; dec_LMPcmd = 1'b0;
  endtask

  // One payload window: n bits of pat (bit i = pat[i%64]), endp with the last bit or one cycle later.
  task automatic packet(input logic [63:0] pat, input int n, input bit endp_last,
                        input bit crc, input bit seqn);
    clear_mon();
    b32_cyc = -1;
    tick(); dec_py_period = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      dec_pybit_valid = 1'b1;
      dec_pybit = pat[i % 64];
      if (i == 31) b32_cyc = cyc;
      if (endp_last && i == n - 1) begin
        dec_py_endp = 1'b1; dec_crc_ok = crc; dec_seqn = seqn; endp_cyc = cyc;
      end
    end
    if (!(endp_last && n > 0)) begin
      tick();
      dec_pybit_valid = 1'b0;
      dec_py_endp = 1'b1; dec_crc_ok = crc; dec_seqn = seqn; endp_cyc = cyc;
    end
    tick();
    dec_pybit_valid = 1'b0; dec_pybit = 1'b0; dec_py_endp = 1'b0;
    repeat (6) tick();
    dec_py_period = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    clear_mon();
    repeat (3) tick();
    check("rst_we", rxlnctrl_we, 0);
    check("rst_addr", rxlnctrl_addr, 0);
    check("rst_din", rxlnctrl_din, 0);
    check("rst_cs", {rxlnctrlacl_cs, rxlnctrlsco_cs}, 0);
    check("rst_cnt", rx_pybitcount, 0);
    check("rst_status", {rxacl_commit_p, rxacl_discard_p, rxacl_dup_p, rx_overflow}, 0);
    rst = 1'b0;
    tick();

    // 40-bit ACL payload, partial last word
    packet(64'h0000_003C_A5A5_A5A5, 40, 1'b0, 1'b1, 1'b0);
    check("p40_nwr", wr_addr.size(), 2);
    check("p40_a0", wa(0), 0);
    check("p40_d0", wd(0), 32'hA5A5_A5A5);
    check("p40_a1", wa(1), 1);
    check("p40_d1", wd(1), 32'h0000_003C);
    check("p40_wlat", (wr_cyc.size() > 0) ? wr_cyc[0] - b32_cyc : -1, 1);
    check("p40_cnt", rx_pybitcount, 40);
    check("p40_commit", commit_cnt, 1);
    check("p40_clat", commit_cyc - endp_cyc, 3);
    check("p40_acl", saw_acl, 1);

    // 32 bits, endp on the last bit
    packet(64'h0000_0000_1234_5678, 32, 1'b1, 1'b1, 1'b1);
    check("p32_nwr", wr_addr.size(), 1);
    check("p32_a0", wa(0), 0);
    check("p32_d0", wd(0), 32'h1234_5678);
    check("p32_cnt", rx_pybitcount, 32);
    check("p32_commit", commit_cnt, 1);
    check("p32_clat", commit_cyc - endp_cyc, 2);

    // SEQN sequence 0,0,1 (last accepted SEQN is 1 here)
    packet(64'h5A, 8, 1'b0, 1'b1, 1'b0);
    check("sq1_commit", commit_cnt, 1);
    check("sq1_dup", dup_cnt, 0);
    packet(64'h5A, 8, 1'b0, 1'b1, 1'b0);
`ifdef RXPY_SEQN_FILTER_EN
    check("sq2_commit", commit_cnt, 0);
    check("sq2_dup", dup_cnt, 1);
`else
    check("sq2_commit", commit_cnt, 1);
    check("sq2_dup", dup_cnt, 0);
`endif
    packet(64'h5A, 8, 1'b0, 1'b1, 1'b1);
    check("sq3_commit", commit_cnt, 1);
    check("sq3_dup", dup_cnt, 0);

    // CRC failure
    packet(64'hFF, 8, 1'b0, 1'b0, 1'b0);
    check("crc_discard", discard_cnt, 1);
    check("crc_commit", commit_cnt, 0);
    check("crc_d0", wd(0), 32'h0000_00FF);

    // SCO reserved slot
    rx_reservedslot = 1'b1;
    slot(1'b0);
    packet(64'h0F, 8, 1'b0, 1'b1, 1'b0);
    check("sco_cs", saw_sco, 1);
    check("sco_nacl", saw_acl, 0);
    check("sco_status", commit_cnt + discard_cnt + dup_cnt, 0);
    check("sco_d0", wd(0), 32'h0000_000F);

    // Same reserved slot carrying an LMP packet routes to ACL
    slot(1'b1);
    packet(64'h0F, 8, 1'b0, 1'b1, 1'b0);
    check("lmp_acl", saw_acl, 1);
    check("lmp_nsco", saw_sco, 0);
    check("lmp_commit", commit_cnt, 1);
    slot(1'b0);
    rx_reservedslot = 1'b0;
    check("cs_excl", both_cnt, 0);

    // Zero-bit payload
    packet(64'h0, 0, 1'b0, 1'b0, 1'b0);
    check("zero_nwr", wr_addr.size(), 0);
    check("zero_discard", discard_cnt, 1);

    // Overflow
    packet({64{1'b1}}, 8200, 1'b0, 1'b1, 1'b1);
    check("ovf_nwr", wr_addr.size(), 256);
    check("ovf_lastaddr", wa(255), 255);
    check("ovf_lastdata", wd(255), 32'hFFFF_FFFF);
    check("ovf_flag", rx_overflow, 1);
    check("ovf_discard", discard_cnt, 1);
    check("ovf_commit", commit_cnt, 0);

    // Reset after 20 bits
    clear_mon();
    tick(); dec_py_period = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); dec_pybit_valid = 1'b1; dec_pybit = 1'b1;
    end
    tick(); rst = 1'b1; dec_pybit_valid = 1'b0; dec_py_period = 1'b0;
    tick();
    check("mrst_we", rxlnctrl_we, 0);
    check("mrst_cnt", rx_pybitcount, 0);
    check("mrst_out", {rxlnctrl_addr, rxlnctrl_din, rx_overflow}, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("mrst_nwr", wr_addr.size(), 0);
    packet(64'h0000_0000_CAFE_F00D, 32, 1'b0, 1'b1, 1'b0);
    check("post_a0", wa(0), 0);
    check("post_d0", wd(0), 32'hCAFE_F00D);
    check("post_commit", commit_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
